// File: rtl/shift_load_reg_n.sv
// Parametrised load/shift register for the ALU shift unit: parallel load in IDLE,
// then a serial LSL/LSR/ASR/ROR sequence of amt steps with a busy/done handshake.
module shift_load_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ser_q, ser_d;

    // One-step shift result and the bit it pushes out, for the latched mode.
    logic [WIDTH-1:0]   shifted;
    logic               shifted_bit;

    always_comb begin
        shifted     = out_q;
        shifted_bit = 1'b0;
        case (mode_q)
            MODE_LSL: begin
                shifted     = {out_q[WIDTH-2:0], ser_in};
                shifted_bit = out_q[WIDTH-1];
            end
            MODE_LSR: begin
                shifted     = {ser_in, out_q[WIDTH-1:1]};
                shifted_bit = out_q[0];
            end
            MODE_ASR: begin
                shifted     = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                shifted_bit = out_q[0];
            end
            MODE_ROR: begin
                shifted     = {out_q[0], out_q[WIDTH-1:1]};
                shifted_bit = out_q[0];
            end
            default: begin
                shifted     = out_q;
                shifted_bit = 1'b0;
            end
        endcase
    end

    always_comb begin
        // NOTE: every _d is given its hold value first so no branch can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        ser_d   = ser_q;

        case (state_q)
            IDLE: begin
                if (ld) begin
                    out_d = in;
                    ser_d = 1'b0;
                end else if (start) begin
                    if (amt == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = amt;
                        mode_d  = mode;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                out_d = shifted;
                ser_d = shifted_bit;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_LSL;
            out_q   <= '0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            ser_q   <= ser_d;
        end
    end

    assign out     = out_q;
    assign ser_out = ser_q;
    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_load_reg_n.sv
// Directed self-checking bench for shift_load_reg_n (WIDTH=8, CNT_W=4): load, each
// shift mode, ROR wrap, amt=0, ld/start priority, mid-shift reset and start during DONE.
module tb_shift_load_reg_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic [7:0] in;
    logic       start;
    logic [3:0] amt;
    logic [1:0] mode;
    logic       ser_in;
    logic [7:0] out;
    logic       ser_out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    shift_load_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .in      (in),
        .start   (start),
        .amt     (amt),
        .mode    (mode),
        .ser_in  (ser_in),
        .out     (out),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from posedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [7:0] e_out, input logic e_ser,
                              input logic e_busy, input logic e_done);
        check({tag, ".out"},     32'(out),     32'(e_out));
        check({tag, ".ser_out"}, 32'(ser_out), 32'(e_ser));
        check({tag, ".busy"},    32'(busy),    32'(e_busy));
        check({tag, ".done"},    32'(done),    32'(e_done));
    endtask

    task automatic load(input logic [7:0] val);
        ld = 1'b1; in = val; start = 1'b0;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b1; in = 8'hFF; start = 1'b0;
        amt = 4'd0; mode = 2'b00; ser_in = 1'b0;

        // Reset dominates a concurrent load
        tick(); tick();
        expect_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Load and hold
        load(8'hA5);
        expect_all("load", 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all("hold", 8'hA5, 1'b0, 1'b0, 1'b0);
        end

        // LSL by 3; mode/amt scrambled after the start edge must not matter
        load(8'h81);
        start = 1'b1; amt = 4'd3; mode = 2'b00; ser_in = 1'b0;
        tick();
        start = 1'b0; amt = 4'hF; mode = 2'b11;
        expect_all("lsl.e0", 8'h81, 1'b0, 1'b1, 1'b0);
        tick(); expect_all("lsl.e1", 8'h02, 1'b1, 1'b1, 1'b0);
        tick(); expect_all("lsl.e2", 8'h04, 1'b0, 1'b1, 1'b0);
        tick(); expect_all("lsl.e3", 8'h08, 1'b0, 1'b0, 1'b1);
        tick(); expect_all("lsl.idle", 8'h08, 1'b0, 1'b0, 1'b0);

        // ASR by 2 replicates the sign bit
        load(8'h90);
        start = 1'b1; amt = 4'd2; mode = 2'b10;
        tick();
        start = 1'b0;
        expect_all("asr.e0", 8'h90, 1'b0, 1'b1, 1'b0);
        tick(); expect_all("asr.e1", 8'hC8, 1'b0, 1'b1, 1'b0);
        tick(); expect_all("asr.e2", 8'hE4, 1'b0, 1'b0, 1'b1);
        tick(); expect_all("asr.idle", 8'hE4, 1'b0, 1'b0, 1'b0);

        // LSR by 4 fills with ser_in=1
        load(8'h0F);
        start = 1'b1; amt = 4'd4; mode = 2'b01; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tick(); expect_all("lsr.e1", 8'h87, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        expect_all("lsr.e3", 8'hE1, 1'b1, 1'b1, 1'b0);
        tick(); expect_all("lsr.e4", 8'hF0, 1'b1, 1'b0, 1'b1);
        ser_in = 1'b0;
        tick(); expect_all("lsr.idle", 8'hF0, 1'b1, 1'b0, 1'b0);

        // ROR by 9 wraps: busy for 9 cycles, ends one place rotated
        load(8'h01);
        start = 1'b1; amt = 4'd9; mode = 2'b11;
        tick();
        start = 1'b0;
        check("ror.busy0", 32'(busy), 32'd1);
        for (int i = 1; i < 9; i++) begin
            tick();
            check("ror.busy", 32'(busy), 32'd1);
        end
        check("ror.e8.out", 32'(out), 32'h01);
        tick(); expect_all("ror.e9", 8'h80, 1'b1, 1'b0, 1'b1);
        tick(); expect_all("ror.idle", 8'h80, 1'b1, 1'b0, 1'b0);

        // amt=0: straight to DONE, out and ser_out untouched
        start = 1'b1; amt = 4'd0; mode = 2'b00;
        tick();
        start = 1'b0;
        expect_all("amt0.done", 8'h80, 1'b1, 1'b0, 1'b1);
        tick(); expect_all("amt0.idle", 8'h80, 1'b1, 1'b0, 1'b0);

        // ld and start together: load wins, start is not queued
        ld = 1'b1; in = 8'h5A; start = 1'b1; amt = 4'd3; mode = 2'b00;
        tick();
        ld = 1'b0; start = 1'b0;
        expect_all("ldstart", 8'h5A, 1'b0, 1'b0, 1'b0);
        tick(); expect_all("ldstart.next", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Reset during SHIFT aborts with no done pulse
        start = 1'b1; amt = 4'd5; mode = 2'b00; ser_in = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        expect_all("abort.e2", 8'h68, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_all("abort.rst", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort.nodone", 32'(done), 32'd0);
            check("abort.nobusy", 32'(busy), 32'd0);
        end

        // start held through SHIFT and DONE is ignored there
        load(8'h11);
        start = 1'b1; amt = 4'd1; mode = 2'b00;
        tick();
        amt = 4'd2;
        expect_all("dstart.e0", 8'h11, 1'b0, 1'b1, 1'b0);
        tick(); expect_all("dstart.e1", 8'h22, 1'b0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        expect_all("dstart.e2", 8'h22, 1'b0, 1'b0, 1'b0);
        tick(); expect_all("dstart.e3", 8'h22, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
